// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. It acks at most one requester per cycle with zero
// latency and never writes while the FIFO reports full.
//
// Build option: define ARB_BURST_EN to let a winner keep the port for up
// to MAX_BURST consecutive words (OWN state). Without it the block
// re-arbitrates after every accepted word and OWN is never entered.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = $clog2(NUM_REQ),
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_mask,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata_in,
    input  logic                       fifo_full,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic [ID_WIDTH-1:0]        grant_id,
    output logic                       busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
    logic [ID_WIDTH-1:0] owner_q,    owner_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                busy_q;

    logic [NUM_REQ-1:0]  eligible_s;
    logic                found_s;
    logic [ID_WIDTH-1:0] winner_s;
    logic [NUM_REQ-1:0]  ack_s;
    logic [NUM_REQ-1:0]  ack_out_s;
    logic [WIDTH-1:0]    wdata_s;
    logic                owner_req_s;

    // Pointer increment that wraps at NUM_REQ, so indices >= NUM_REQ never appear.
    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] i);
        if (i >= ID_WIDTH'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return i + ID_WIDTH'(1);
        end
    endfunction

    // Search position k relative to base, modulo NUM_REQ.
    function automatic int rr_index(input logic [ID_WIDTH-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
        end else begin
            j = j;
        end
        return j;
    endfunction

    assign eligible_s  = req & req_mask;
    // A masked owner is treated exactly like an owner that dropped req.
    assign owner_req_s = req[owner_q] & req_mask[owner_q];

    // Round-robin search: walk from rr_ptr upward; the first eligible index wins.
    // Iterating from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if ((rr_index(rr_ptr_q, k) < NUM_REQ) && eligible_s[rr_index(rr_ptr_q, k)]) begin
                found_s  = 1'b1;
                winner_s = ID_WIDTH'(rr_index(rr_ptr_q, k));
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // FSM next-state, pointer/owner/count updates and the zero-latency ack.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        ack_s       = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s && !fifo_full) begin
                    ack_s[winner_s] = 1'b1;
                    owner_d         = winner_s;
                    grant_id_d      = winner_s;
`ifdef ARB_BURST_EN
                    if (MAX_BURST > 1) begin
                        state_d     = ST_OWN;
                        burst_cnt_d = CNT_W'(1);
                    end else begin
                        // A one-word burst ends on its first word.
                        rr_ptr_d    = next_ptr(winner_s);
                        burst_cnt_d = '0;
                    end
`else
                    rr_ptr_d = next_ptr(winner_s);
`endif
                end else begin
                    // Nothing eligible, or FIFO full: hold everything.
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    // Owner released the port: hand over to the next index.
                    state_d     = ST_IDLE;
                    rr_ptr_d    = next_ptr(owner_q);
                    burst_cnt_d = '0;
                end else if (!fifo_full) begin
                    ack_s[owner_q] = 1'b1;
                    grant_id_d     = owner_q;
                    if (burst_cnt_q >= CNT_W'(MAX_BURST - 1)) begin
                        // This edge accepts word MAX_BURST: burst is over.
                        state_d     = ST_IDLE;
                        rr_ptr_d    = next_ptr(owner_q);
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // FIFO full inside a burst: keep ownership and count.
                    state_d = ST_OWN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Reset overrides the combinational ack so nothing is written during reset.
    always_comb begin
        if (res) begin
            ack_out_s = '0;
        end else begin
            ack_out_s = ack_s;
        end
    end

    // Write-data mux: select the acknowledged requester's word, zero otherwise.
    always_comb begin
        wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_out_s[i]) begin
                wdata_s = wdata_in[i*WIDTH +: WIDTH];
            end else begin
                wdata_s = wdata_s;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= (state_d == ST_OWN);
        end
    end

    assign ack        = ack_out_s;
    assign fifo_wr_en = |ack_out_s;
    assign fifo_wdata = wdata_s;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;

endmodule
